// File: rtl/bcd_date_counter.sv
// BCD calendar date counter YYYYMMDD with day_tick advance and validated load.
// Optional weekday tracking is enabled by defining WEEKDAY_EN.
`timescale 1ns/1ps
module bcd_date_counter #(
    parameter logic [15:0] RST_YEAR  = 16'h2000,
    parameter logic [7:0]  RST_MONTH = 8'h01,
    parameter logic [7:0]  RST_DAY   = 8'h01
) (
    input  logic        clk_1khz,
    input  logic        rst_n,
    input  logic        day_tick,
    input  logic        set_valid,
    input  logic [31:0] set_date,
`ifdef WEEKDAY_EN
    input  logic [2:0]  set_weekday,
    output logic [2:0]  weekday,
`endif
    output logic        set_err,
    output logic        year_wrap,
    output logic [3:0]  num1,
    output logic [3:0]  num2,
    output logic [3:0]  num3,
    output logic [3:0]  num4,
    output logic [3:0]  num5,
    output logic [3:0]  num6,
    output logic [3:0]  num7,
    output logic [3:0]  num8
);

    // Leap test on BCD digits: century digits decide only when the two low digits are 00.
    function automatic logic is_leap(input logic [15:0] y);
        logic [6:0] v;
        if (y[7:0] == 8'h00)
            v = 7'(y[15:12]) * 7'd10 + 7'(y[11:8]);
        else
            v = 7'(y[7:4]) * 7'd10 + 7'(y[3:0]);
        return (v[1:0] == 2'b00);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic leap);
        case (m)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: return 8'h31;
            8'h04, 8'h06, 8'h09, 8'h11:                      return 8'h30;
            8'h02:                                           return leap ? 8'h29 : 8'h28;
            default:                                         return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Returns {carry_out, year+1}; carry_out marks the 9999 -> 0000 wrap.
    function automatic logic [16:0] bcd_inc_year(input logic [15:0] y);
        logic [15:0] r;
        logic        c;
        r = y;
        c = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    function automatic logic all_bcd(input logic [31:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 8; i++)
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    logic [31:0] date_q, date_d;
    logic        err_d, wrap_d;
    logic [7:0]  cur_dim, set_dim;
    logic [16:0] year_inc;
    logic        set_ok;

`ifdef WEEKDAY_EN
    logic [2:0]  wd_d;
`endif

    assign cur_dim  = days_in_month(date_q[15:8], is_leap(date_q[31:16]));
    assign set_dim  = days_in_month(set_date[15:8], is_leap(set_date[31:16]));
    assign year_inc = bcd_inc_year(date_q[31:16]);

    // Unsigned compare is a valid BCD compare once every nibble is known to be <= 9.
    always_comb begin
        set_ok = all_bcd(set_date) && (set_dim != 8'h00) &&
                 (set_date[7:0] != 8'h00) && (set_date[7:0] <= set_dim);
`ifdef WEEKDAY_EN
        if (set_weekday == 3'd7) set_ok = 1'b0;
`endif
    end

    always_comb begin
        date_d = date_q;
        err_d  = 1'b0;
        wrap_d = 1'b0;
`ifdef WEEKDAY_EN
        wd_d   = weekday;
`endif
        if (set_valid) begin
            if (set_ok) begin
                date_d = set_date;
`ifdef WEEKDAY_EN
                wd_d   = set_weekday;
`endif
            end else begin
                err_d = 1'b1;
            end
        end else if (day_tick) begin
`ifdef WEEKDAY_EN
            wd_d = (weekday == 3'd6) ? 3'd0 : weekday + 3'd1;
`endif
            if (date_q[7:0] < cur_dim) begin
                date_d[7:0] = bcd_inc2(date_q[7:0]);
            end else begin
                date_d[7:0] = 8'h01;
                if (date_q[15:8] == 8'h12) begin
                    date_d[15:8]  = 8'h01;
                    date_d[31:16] = year_inc[15:0];
                    wrap_d        = year_inc[16];
                end else begin
                    date_d[15:8] = bcd_inc2(date_q[15:8]);
                end
            end
        end
    end

    always_ff @(posedge clk_1khz) begin
        if (!rst_n) begin
            date_q    <= {RST_YEAR, RST_MONTH, RST_DAY};
            set_err   <= 1'b0;
            year_wrap <= 1'b0;
`ifdef WEEKDAY_EN
            weekday   <= 3'd6;
`endif
        end else begin
            date_q    <= date_d;
            set_err   <= err_d;
            year_wrap <= wrap_d;
`ifdef WEEKDAY_EN
            weekday   <= wd_d;
`endif
        end
    end

    assign {num1, num2, num3, num4, num5, num6, num7, num8} = date_q;

endmodule

// File: tb/tb_bcd_date_counter.sv
// Directed bench for bcd_date_counter with an integer-calendar reference model and scoreboard.
`timescale 1ns/1ps
module tb_bcd_date_counter;

    logic        clk_1khz = 1'b0;
    logic        rst_n, day_tick, set_valid;
    logic [31:0] set_date;
    logic [2:0]  set_weekday, weekday;
    logic        set_err, year_wrap;
    logic [3:0]  num1, num2, num3, num4, num5, num6, num7, num8;

    int cmp_n = 0;
    int mis_n = 0;

    bcd_date_counter #(.RST_YEAR(16'h2000), .RST_MONTH(8'h01), .RST_DAY(8'h01)) dut (
        .clk_1khz(clk_1khz), .rst_n(rst_n), .day_tick(day_tick),
        .set_valid(set_valid), .set_date(set_date),
`ifdef WEEKDAY_EN
        .set_weekday(set_weekday), .weekday(weekday),
`endif
        .set_err(set_err), .year_wrap(year_wrap),
        .num1(num1), .num2(num2), .num3(num3), .num4(num4),
        .num5(num5), .num6(num6), .num7(num7), .num8(num8)
    );

`ifndef WEEKDAY_EN
    assign weekday = 3'd0;
`endif

    always #5 clk_1khz = ~clk_1khz;

    typedef struct {
        logic [31:0] date;
        logic        err;
        logic        wrap;
        logic [2:0]  wd;
        string       tag;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_date;
    logic [2:0]  m_wd;

    function automatic int b2i(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] i2b(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic bit m_leap(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int m_dim(input int m, input int y);
        case (m)
            2:           return m_leap(y) ? 29 : 28;
            4, 6, 9, 11: return 30;
            default:     return 31;
        endcase
    endfunction

    function automatic bit model_valid(input logic [31:0] sd, input logic [2:0] swd);
        int y, m, d;
        for (int i = 0; i < 8; i++)
            if (sd[4*i +: 4] > 4'd9) return 1'b0;
        y = b2i(sd[31:16]);
        m = b2i({8'h00, sd[15:8]});
        d = b2i({8'h00, sd[7:0]});
        if (m < 1 || m > 12) return 1'b0;
        if (d < 1 || d > m_dim(m, y)) return 1'b0;
`ifdef WEEKDAY_EN
        if (swd == 3'd7) return 1'b0;
`else
        if (swd == 3'd7) return 1'b1;
`endif
        return 1'b1;
    endfunction

    task automatic model_tick(output logic wrap);
        int y, m, d;
        logic [15:0] yb, mb, db;
        y = b2i(m_date[31:16]);
        m = b2i({8'h00, m_date[15:8]});
        d = b2i({8'h00, m_date[7:0]});
        wrap = 1'b0;
        if (d < m_dim(m, y)) begin
            d++;
        end else begin
            d = 1;
            if (m == 12) begin
                m = 1;
                if (y == 9999) begin
                    y = 0;
                    wrap = 1'b1;
                end else begin
                    y++;
                end
            end else begin
                m++;
            end
        end
        yb = i2b(y);
        mb = i2b(m);
        db = i2b(d);
        m_date = {yb, mb[7:0], db[7:0]};
        m_wd = (m_wd == 3'd6) ? 3'd0 : m_wd + 3'd1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_n++;
        assert (obs === exp) else begin
            mis_n++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    // Drive one cycle of inputs, queue the model's prediction, then compare after the edge.
    task automatic step(input logic r, input logic sv, input logic [31:0] sd,
                        input logic tk, input logic [2:0] swd, input string tag);
        exp_t e, got;
        rst_n = r; set_valid = sv; set_date = sd; day_tick = tk; set_weekday = swd;
        e.err = 1'b0;
        e.wrap = 1'b0;
        if (!r) begin
            m_date = 32'h2000_0101;
            m_wd   = 3'd6;
        end else if (sv) begin
            if (model_valid(sd, swd)) begin
                m_date = sd;
                m_wd   = swd;
            end else begin
                e.err = 1'b1;
            end
        end else if (tk) begin
            model_tick(e.wrap);
        end
        e.date = m_date;
        e.wd   = m_wd;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk_1khz);
        #1;
        rst_n = 1'b1; set_valid = 1'b0; day_tick = 1'b0;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check({got.tag, "_date"}, {num1, num2, num3, num4, num5, num6, num7, num8}, got.date);
            check({got.tag, "_err"}, 32'(set_err), 32'(got.err));
            check({got.tag, "_wrap"}, 32'(year_wrap), 32'(got.wrap));
`ifdef WEEKDAY_EN
            check({got.tag, "_wd"}, 32'(weekday), 32'(got.wd));
`endif
        end
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] bad [5];
        bad = '{32'h2023_0229, 32'h2023_1301, 32'h2023_0400, 32'h20A3_0101, 32'h2023_0431};
        rst_n = 1'b1; set_valid = 1'b0; day_tick = 1'b0; set_date = '0; set_weekday = '0;
        m_date = '0; m_wd = '0;
        #1;
        step(1'b0, 1'b0, '0, 1'b0, 3'd0, "reset0");
        step(1'b0, 1'b0, '0, 1'b0, 3'd0, "reset1");
        step(1'b1, 1'b0, '0, 1'b0, 3'd0, "post_reset");
        check("reset_const", {num1, num2, num3, num4, num5, num6, num7, num8}, 32'h2000_0101);

        step(1'b1, 1'b1, 32'h2024_0228, 1'b0, 3'd3, "set_2024");
        step(1'b1, 1'b0, '0, 1'b1, 3'd0, "feb29_2024");
        step(1'b1, 1'b0, '0, 1'b1, 3'd0, "mar01_2024");
        step(1'b1, 1'b1, 32'h2023_0228, 1'b0, 3'd2, "set_2023");
        step(1'b1, 1'b0, '0, 1'b1, 3'd0, "mar01_2023");
        step(1'b1, 1'b1, 32'h2100_0228, 1'b0, 3'd0, "set_2100");
        step(1'b1, 1'b0, '0, 1'b1, 3'd0, "mar01_2100");
        step(1'b1, 1'b1, 32'h2000_0228, 1'b0, 3'd1, "set_2000");
        step(1'b1, 1'b0, '0, 1'b1, 3'd0, "feb29_2000");
        step(1'b1, 1'b0, '0, 1'b1, 3'd0, "mar01_2000");

        step(1'b1, 1'b1, 32'h9999_1231, 1'b0, 3'd5, "set_9999");
        step(1'b1, 1'b0, '0, 1'b1, 3'd0, "wrap_tick");
        step(1'b1, 1'b0, '0, 1'b0, 3'd0, "wrap_clear");
        step(1'b1, 1'b1, 32'h1999_1231, 1'b0, 3'd5, "set_1999");
        step(1'b1, 1'b0, '0, 1'b1, 3'd0, "y2k_nowrap");

        foreach (bad[i]) begin
            step(1'b1, 1'b1, bad[i], 1'b0, 3'd0, $sformatf("bad_set_%0d", i));
            step(1'b1, 1'b0, '0, 1'b0, 3'd0, $sformatf("bad_clear_%0d", i));
        end

        step(1'b1, 1'b1, 32'h2022_0615, 1'b1, 3'd3, "collide");
        step(1'b0, 1'b1, 32'h2023_0101, 1'b0, 3'd0, "rst_over_set");
`ifdef WEEKDAY_EN
        step(1'b1, 1'b1, 32'h2022_0101, 1'b0, 3'd7, "bad_weekday");
`endif

        step(1'b1, 1'b1, 32'h2024_0101, 1'b0, 3'd1, "set_long");
        for (int n = 0; n < 366; n++)
            step(1'b1, 1'b0, '0, 1'b1, 3'd0, "long");
        check("long_end_const", {num1, num2, num3, num4, num5, num6, num7, num8}, 32'h2025_0101);
`ifdef WEEKDAY_EN
        check("long_end_wd", 32'(weekday), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
        $finish;
    end

endmodule
